// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 2-flop input synchronizer, mid-bit sampling,
// framing-error detection and a recover state that waits for the line to return high.
module uart_rx #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_busy,
   output logic       frame_err
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_t;

   state_t          state, nxt;
   logic [1:0]      sync;
   logic            rxs;
   logic [CW-1:0]   cnt, cnt_n;
   logic [2:0]      idx, idx_n;
   logic [7:0]      shreg, shreg_n;
   logic            valid_n, ferr_n;

   assign rxs = sync[1];

   always_comb begin
      nxt     = state;
      cnt_n   = cnt + CW'(1);
      idx_n   = idx;
      shreg_n = shreg;
      valid_n = 1'b0;
      ferr_n  = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            nxt   = rxs ? IDLE : START;
         end
         START: if (cnt == HALF_LAST) begin
            cnt_n = '0;
            idx_n = '0;
            nxt   = rxs ? IDLE : DATA;
         end
         DATA: if (cnt == BIT_LAST) begin
            cnt_n        = '0;
            shreg_n[idx] = rxs;
            idx_n        = idx + 3'd1;
            nxt          = (idx == 3'd7) ? STOP : DATA;
         end
         STOP: if (cnt == BIT_LAST) begin
            cnt_n   = '0;
            valid_n = rxs;
            ferr_n  = !rxs;
            nxt     = rxs ? IDLE : RECOVER;
         end
         RECOVER: begin
            cnt_n = '0;
            nxt   = rxs ? IDLE : RECOVER;
         end
         default: begin
            cnt_n = '0;
            nxt   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync      <= 2'b11;
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         rx_busy   <= 1'b0;
      end else begin
         sync      <= {sync[0], rx};
         state     <= nxt;
         cnt       <= cnt_n;
         idx       <= idx_n;
         shreg     <= shreg_n;
         rx_data   <= valid_n ? shreg : rx_data;
         rx_valid  <= valid_n;
         frame_err <= ferr_n;
         rx_busy   <= nxt != IDLE;
      end
   end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames against a timing-offset model of the receiver,
// compared every cycle, plus literal checks for the directed scenarios.
module tb_uart_rx;
   localparam int N = 16;
   localparam int HALF = N / 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, rx_busy, frame_err;

   int vectors = 0, miscompares = 0, cyc = 0;
   int n_valid = 0, n_ferr = 0, last_valid_cyc = 0, busy_run = 0, busy_max = 0;
   logic [7:0] logq[$];

   logic q0 = 1'b1, q1 = 1'b1;
   int mode = 0, ts = 0;
   logic [7:0] bits = '0, m_data = '0;
   logic m_valid = 1'b0, m_ferr = 1'b0, m_busy = 1'b0;

   uart_rx #(.CLKS_PER_BIT(N)) dut (
      .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_busy(rx_busy), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int got, input int exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Model: mode 0 idle, 1 in frame (ts = cycle the start was seen), 2 waiting for line high
   always @(posedge clk) begin : model
      logic s;
      int off, k;
      cyc++;
      m_valid = 1'b0;
      m_ferr  = 1'b0;
      if (!rst) begin
         q0 = 1'b1; q1 = 1'b1; mode = 0; m_data = '0; m_busy = 1'b0;
      end else begin
         s = q1; q1 = q0; q0 = rx;
         if (mode == 0) begin
            if (!s) begin mode = 1; ts = cyc; end
         end else if (mode == 1) begin
            off = cyc - ts;
            if (off == HALF) begin
               if (s) mode = 0;
            end else if (off > HALF && (off - HALF) % N == 0) begin
               k = (off - HALF) / N;
               if (k <= 8) bits[k-1] = s;
               else if (s) begin m_valid = 1'b1; m_data = bits; mode = 0; end
               else begin m_ferr = 1'b1; mode = 2; end
            end
         end else if (s) mode = 0;
         m_busy = mode != 0;
      end
      #1;
      check("valid", rx_valid, m_valid);
      check("frame_err", frame_err, m_ferr);
      check("busy", rx_busy, m_busy);
      check("data", rx_data, m_data);
      if (rx_valid) begin n_valid++; last_valid_cyc = cyc; logq.push_back(rx_data); end
      if (frame_err) n_ferr++;
      busy_run = rx_busy ? busy_run + 1 : 0;
      if (busy_run > busy_max) busy_max = busy_run;
   end

   task automatic put(input logic v, input int n);
      rx = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b, input logic stop);
      put(1'b0, N);
      for (int i = 0; i < 8; i++) put(b[i], N);
      put(stop, N);
   endtask

   initial begin
      int v0, f0, t0, lat, good;
      logic [7:0] d, b;
      repeat (3) @(negedge clk);
      check("rst_data", rx_data, 8'h00);
      check("rst_valid", rx_valid, 0);
      check("rst_busy", rx_busy, 0);
      check("rst_ferr", frame_err, 0);
      rst = 1'b1;
      put(1'b1, 5);

      v0 = n_valid;
      send(8'hA5, 1'b1);
      put(1'b1, 20);
      check("a5_count", n_valid - v0, 1);
      check("a5_data", rx_data, 8'hA5);
      check("a5_ferr", n_ferr, 0);
      check("a5_busy", rx_busy, 0);

      v0 = n_valid;
      send(8'h3C, 1'b1);
      send(8'hC3, 1'b1);
      put(1'b1, 10);
      check("b2b_count", n_valid - v0, 2);
      check("b2b_first", logq[logq.size()-2], 8'h3C);
      check("b2b_second", logq[logq.size()-1], 8'hC3);

      v0 = n_valid; f0 = n_ferr; busy_max = 0;
      put(1'b0, 4);
      put(1'b1, 30);
      check("glitch_valid", n_valid - v0, 0);
      check("glitch_ferr", n_ferr - f0, 0);
      check("glitch_busy_le10", (busy_max <= 10) ? 1 : busy_max, 1);

      v0 = n_valid; f0 = n_ferr; d = rx_data;
      send(8'h55, 1'b0);
      put(1'b0, 40);
      check("ferr_busy_held", rx_busy, 1);
      put(1'b1, N);
      check("ferr_count", n_ferr - f0, 1);
      check("ferr_valid", n_valid - v0, 0);
      check("ferr_data_kept", rx_data, d);
      send(8'h0F, 1'b1);
      put(1'b1, 10);
      check("after_ferr_data", rx_data, 8'h0F);

      v0 = n_valid; f0 = n_ferr;
      put(1'b0, N);
      for (int i = 0; i < 4; i++) put(1'b1, N);
      rx = 1'b1;
      repeat (HALF) @(negedge clk);
      rst = 1'b0;
      put(1'b1, 3);
      check("midrst_data", rx_data, 8'h00);
      check("midrst_busy", rx_busy, 0);
      rst = 1'b1;
      put(1'b1, 10);
      check("midrst_no_pulse", (n_valid - v0) + (n_ferr - f0), 0);
      check("midrst_data_hold", rx_data, 8'h00);
      send(8'h81, 1'b1);
      put(1'b1, 5);
      check("midrst_81", rx_data, 8'h81);
      check("midrst_count", n_valid - v0, 1);

      t0 = cyc;
      send(8'h00, 1'b1);
      put(1'b1, 5);
      lat = last_valid_cyc - t0;
      check("latency", (lat >= 155 && lat <= 157) ? 156 : lat, 156);
      check("zero_data", rx_data, 8'h00);

      v0 = n_valid; good = 0;
      for (int it = 0; it < 40; it++) begin
         int r;
         r = $urandom_range(0, 9);
         b = 8'($urandom);
         if (r == 0) begin
            put(1'b0, $urandom_range(1, 6));
            put(1'b1, $urandom_range(HALF + 2, 2 * N));
         end else if (r == 1) begin
            send(b, 1'b0);
            put(1'b0, $urandom_range(0, 20));
            put(1'b1, $urandom_range(1, 5));
         end else begin
            send(b, 1'b1);
            good++;
            put(1'b1, $urandom_range(0, 3));
         end
      end
      put(1'b1, 30);
      check("rand_count", n_valid - v0, good);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208, clock cycles per serial bit (50 MHz / 9600 baud); legal range 4..65535.
REQ-002 Port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset; synchronous, active-low.
REQ-004 Port rx  input  1  asynchronous serial line; idles high.
REQ-005 Port rx_data  output  8  last correctly framed byte received.
REQ-006 Port rx_valid  output  1  one-cycle pulse: rx_data holds a new byte.
REQ-007 Port rx_busy  output  1  high while a frame is in progress.
REQ-008 Port frame_err  output  1  one-cycle pulse: stop bit sampled low.

Function
REQ-009 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, one stop bit 1, no parity.
REQ-010 rx SHALL pass through a 2-flop synchronizer (reset value 1) before any use; all references to rx below mean the synchronized value.
REQ-011 State machine SHALL have states IDLE, START, DATA, STOP, RECOVER.
REQ-012 IDLE: on rx = 0, clear baud counter, go to START.
REQ-013 START: after CLKS_PER_BIT/2 cycles (integer division), sample rx; 0 -> clear counter and bit index, go to DATA; 1 -> glitch, return to IDLE with no output pulse.
REQ-014 DATA: every CLKS_PER_BIT cycles sample rx into shift register bit position = bit index (0..7); after the 8th sample go to STOP.
REQ-015 STOP: after CLKS_PER_BIT cycles sample rx; 1 -> load rx_data from shift register, pulse rx_valid, go to IDLE; 0 -> pulse frame_err, leave rx_data unchanged, go to RECOVER.
REQ-016 RECOVER: remain until rx = 1, then go to IDLE; no new frame accepted while in RECOVER.
REQ-017 rx_valid and frame_err SHALL be high for exactly one clk cycle, registered, in the cycle after the stop-bit sample; they SHALL never be high together.
REQ-018 rx_data SHALL change only in the cycle rx_valid rises and SHALL hold its value otherwise.
REQ-019 rx_busy SHALL be 1 in START, DATA, STOP, RECOVER and 0 in IDLE, registered alongside state.
REQ-020 Baud counter SHALL be wide enough for CLKS_PER_BIT-1 with no wrap; it resets to 0 on every sample point.
REQ-021 Back-to-back frames: a start edge in the cycle after returning to IDLE SHALL be accepted with no lost byte.
REQ-022 Latency: rx_valid SHALL rise (CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 4) +/- 1 cycles after the start-bit falling edge on the raw rx pin (2 synchronizer cycles included).

Reset
REQ-023 While rst = 0 at a rising clk edge: state IDLE, rx_data 8'h00, rx_valid 0, frame_err 0, rx_busy 0, counters 0, synchronizer flops 1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no rx_valid or frame_err pulse; after release the block SHALL wait in IDLE for the next falling edge.

Verification (CLKS_PER_BIT = 16 for all scenarios)
REQ-025 Send 8'hA5 framed 8N1 -> exactly one rx_valid pulse, rx_data = 8'hA5, frame_err never high, rx_busy low afterward.
REQ-026 Send 8'h3C then 8'hC3 back-to-back with no idle gap -> two rx_valid pulses, rx_data 8'h3C then 8'hC3.
REQ-027 Pulse rx low for 4 cycles then high -> return to IDLE, no rx_valid, no frame_err, rx_busy high at most 8+2 cycles.
REQ-028 Send 8'h55 with stop bit 0, hold rx low 40 cycles, then high -> one frame_err pulse, rx_data unchanged, rx_busy stays high until rx returns high; a following 8'h0F is received correctly.
REQ-029 Assert rst during data bit 4 of 8'hFF, release, send 8'h81 -> no pulse for the aborted frame, rx_data = 8'h00 until 8'h81 is received, then rx_data = 8'h81.
REQ-030 Measure raw-rx falling edge to rx_valid for 8'h00 -> 156 +/- 1 cycles.
